// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Purpose: single-outstanding-request instruction fetch stage. Issues one read
// per instruction to the instruction memory, presents the returned word to the
// IF/ID register, absorbs one early return in a skid buffer while the output is
// stalled, and redirects on a taken branch (late returns for the squashed
// request are dropped through the kill flag).
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   IF/ID hold; current output is not consumed
//   branch_taken   in   redirect request, highest priority
//   branch_target  in   redirect address (low two bits ignored)
//   imem_req       out  read request pulse (combinational from state/inputs)
//   imem_addr      out  read address, meaningful while imem_req=1
//   imem_rvalid    in   read data strobe
//   imem_rdata     in   read data
//   Instruction    out  instruction word to IF/ID
//   Inst_Addr      out  address of Instruction
//   inst_valid     out  Instruction/Inst_Addr are live
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned         ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic              inst_valid
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         skid_inst;
    logic [ADDR_W-1:0]   skid_addr;
    logic                skid_valid;
    logic                kill;
    logic                out_free;

    // Output register can accept new data: empty, or being consumed this cycle.
    assign out_free = !inst_valid || !stall;

    // Request is issued the same cycle the FSM decides to fetch, so the
    // memory sees it at the edge that moves the FSM into WAIT.
    assign imem_req  = (state == FETCH) && !rst && !branch_taken && out_free;
    assign imem_addr = pc;

    // Fetch FSM with registered outputs, skid buffer and kill tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= '0;
            kill        <= 1'b0;
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_addr   <= '0;
            inst_valid  <= 1'b0;
            Instruction <= '0;
            Inst_Addr   <= '0;
        end else if (branch_taken) begin
            pc         <= branch_target & ALIGN_MASK;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
            // A request still in flight must have its return dropped later.
            if (state == WAIT && !imem_rvalid) begin
                kill <= 1'b1;
            end else begin
                kill  <= 1'b0;
                state <= FETCH;
            end
        end else begin
            // Consumption empties the output unless a load below overrides it.
            if (inst_valid && !stall) begin
                inst_valid <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (out_free) begin
                        req_addr <= pc;
                        pc       <= pc + PC_STEP;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= FETCH;
                        end else if (out_free) begin
                            Instruction <= imem_rdata;
                            Inst_Addr   <= req_addr;
                            inst_valid  <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            skid_inst  <= imem_rdata;
                            skid_addr  <= req_addr;
                            skid_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        Instruction <= skid_inst;
                        Inst_Addr   <= skid_addr;
                        inst_valid  <= skid_valid;
                        skid_valid  <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Purpose: randomized bench for instruction_fetch_unit. A behavioural memory
// answers requests with variable latency; the stimulus process keeps a queue of
// the addresses the IF/ID stage must receive in program order (sequential from
// the last reset/redirect point), and an independent monitor pops that queue on
// every consumed instruction and checks protocol rules each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    localparam int unsigned ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .Instruction   (Instruction),
        .Inst_Addr     (Inst_Addr),
        .inst_valid    (inst_valid)
    );

    // Memory contents: a distinct word per aligned address.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    // Behavioural instruction memory, latency 1..max_lat cycles, reset with rst.
    int unsigned max_lat = 1;
    int unsigned lat;
    int unsigned mem_wait;
    logic        mem_busy = 1'b0;
    logic [63:0] mem_addr_q = 64'h0;

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= $urandom();
        if (rst) begin
            mem_busy <= 1'b0;
        end else if (imem_req && !mem_busy) begin
            lat = $urandom_range(max_lat, 1);
            if (lat == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word_of(imem_addr);
            end else begin
                mem_busy   <= 1'b1;
                mem_addr_q <= imem_addr;
                mem_wait   <= lat - 1;
            end
        end else if (mem_busy) begin
            if (mem_wait <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word_of(mem_addr_q);
                mem_busy    <= 1'b0;
            end else begin
                mem_wait <= mem_wait - 1;
            end
        end
    end

    // Reference model: expected program-order stream of consumed addresses.
    logic [63:0] exp_q[$];
    logic [63:0] push_next;
    int          phase = 0;

    task automatic refill();
        while (exp_q.size() < 32) begin
            exp_q.push_back(push_next);
            push_next = push_next + 64'd4;
        end
    endtask

    task automatic redirect(input logic [63:0] a);
        exp_q.delete();
        push_next = a;
        refill();
    endtask

    // Monitor / scoreboard.
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rel_cyc  = 0;
    int          last_cons = -1;
    int          idle     = 0;
    int          exp_cyc;
    logic        prev_rst = 1'b1;
    logic [63:0] e;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check(imem_req == 1'b0, "req_during_reset", 64'(imem_req), 64'd0);
        end else begin
            if (prev_rst) begin
                check(inst_valid == 1'b0, "reset_inst_valid", 64'(inst_valid), 64'd0);
                check(Instruction == 32'h0, "reset_instruction", 64'(Instruction), 64'd0);
                check(Inst_Addr == 64'h0, "reset_inst_addr", Inst_Addr, 64'd0);
                rel_cyc   = cyc;
                last_cons = -1;
                if (!branch_taken) begin
                    check(imem_req == 1'b1, "first_req", 64'(imem_req), 64'd1);
                    check(imem_addr == RESET_PC, "first_req_addr", imem_addr, RESET_PC);
                end
            end
            if (branch_taken) begin
                check(imem_req == 1'b0, "req_on_branch", 64'(imem_req), 64'd0);
            end
            if (imem_req) begin
                check(!mem_busy, "single_outstanding", 64'(mem_busy), 64'd0);
            end
            if (inst_valid && !stall && !branch_taken) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    check(1'b0, "scoreboard_empty", Inst_Addr, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(Inst_Addr == e, "inst_addr", Inst_Addr, e);
                    check(Instruction == word_of(e), "instruction", 64'(Instruction), 64'(word_of(e)));
                end
                if (phase == 0) begin
                    exp_cyc = (last_cons < 0) ? rel_cyc + 2 : last_cons + 2;
                    check(cyc == exp_cyc, "latency_cycle", 64'(cyc), 64'(exp_cyc));
                end
                last_cons = cyc;
            end else begin
                idle++;
                if (idle >= 100) begin
                    check(1'b0, "progress_timeout", 64'(idle), 64'd0);
                    idle = 0;
                end
            end
        end
        prev_rst = rst;
    end

    // Stimulus.
    int          stall_hold = 0;
    logic [63:0] tgt;

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        redirect(RESET_PC);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed: 1-cycle memory, no stall, no branch.
        repeat (24) begin
            @(posedge clk);
            #1 refill();
        end

        phase   = 1;
        max_lat = 3;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(199, 0) == 0);
            if (stall_hold > 0) begin
                stall_hold--;
            end else if ($urandom_range(7, 0) == 0) begin
                stall_hold = $urandom_range(6, 1);
            end
            stall        = (stall_hold > 0) || ($urandom_range(3, 0) == 0);
            branch_taken = !rst && ($urandom_range(19, 0) == 0);
            if ($urandom_range(2, 0) == 0) begin
                tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            end else begin
                tgt = 64'($urandom_range(32'h0000_FFFF, 0));
            end
            branch_target = tgt;
            if (rst) begin
                redirect(RESET_PC);
            end else if (branch_taken) begin
                redirect(tgt & ~64'h3);
            end else begin
                refill();
            end
        end

        @(posedge clk);
        #1;
        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        refill();
        repeat (10) begin
            @(posedge clk);
            #1 refill();
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, address of the first fetch after reset.
REQ-002 SHALL have parameter ADDR_W, default 64, width of the PC and all addresses.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  hazard unit holds IF/ID; the current output is not consumed.
REQ-006 SHALL have port branch_taken  input  1  EX/MEM redirect request (PCSrc).
REQ-007 SHALL have port branch_target  input  ADDR_W  redirect address (EX/MEM Adder_Result_Out).
REQ-008 SHALL have port imem_req  output  1  instruction memory read request, one-cycle pulse.
REQ-009 SHALL have port imem_addr  output  ADDR_W  read address, valid while imem_req=1.
REQ-010 SHALL have port imem_rvalid  input  1  read data return strobe, at least 1 cycle after imem_req.
REQ-011 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-012 SHALL have port Instruction  output  32  instruction to IF/ID.
REQ-013 SHALL have port Inst_Addr  output  ADDR_W  address of Instruction.
REQ-014 SHALL have port inst_valid  output  1  Instruction/Inst_Addr hold a live instruction.

Function
REQ-015 SHALL contain: pc register, req_addr register, output register (Instruction, Inst_Addr, inst_valid), one-entry skid buffer (skid_inst, skid_addr), kill flag, and FSM with states FETCH, WAIT, HOLD.
REQ-016 SHALL allow at most one outstanding memory request.
REQ-017 Output consumed in a cycle SHALL mean inst_valid=1 and stall=0. When consumed and no new data is loaded, inst_valid SHALL go to 0.
REQ-018 FETCH: when branch_taken=0 and (inst_valid=0 or stall=0), SHALL drive imem_req=1 and imem_addr=pc. Same edge: req_addr<=pc, pc<=pc+4 (mod 2^ADDR_W), state->WAIT. Otherwise imem_req=0 and the unit stays in FETCH.
REQ-019 WAIT: imem_req=0. On imem_rvalid=1 with kill=0 and branch_taken=0:
- if the output is free or consumed this cycle: output<=imem_rdata/req_addr, inst_valid<=1, state->FETCH.
- otherwise: skid<=imem_rdata/req_addr, state->HOLD.
REQ-020 WAIT with imem_rvalid=1 and kill=1 SHALL discard the data, clear kill, and go to FETCH.
REQ-021 HOLD: imem_req=0. When stall=0, SHALL set output<=skid, inst_valid<=1, and go to FETCH.
REQ-022 branch_taken=1 SHALL take priority over stall and all other events. It SHALL:
- set pc<=branch_target with bits [1:0] forced to 0;
- set inst_valid<=0 and invalidate the skid buffer;
- suppress imem_req in that cycle.
REQ-023 branch_taken in FETCH or HOLD SHALL go to FETCH. In WAIT without imem_rvalid it SHALL set kill<=1 and stay in WAIT. In WAIT together with imem_rvalid it SHALL discard the data, leave kill=0, and go to FETCH.
REQ-024 imem_rvalid outside WAIT SHALL be ignored.
REQ-025 Latency: with 1-cycle memory, request at edge N and rvalid in cycle N+1 SHALL give inst_valid=1 in cycle N+2. Steady-state throughput SHALL be one instruction per 2 cycles.
REQ-026 inst_valid=0 SHALL leave Instruction/Inst_Addr holding their last values (don't-care to IF/ID).

Reset
REQ-027 On rst=1 at an edge, from any state including WAIT with a request outstanding: pc<=RESET_PC, state<=FETCH, kill<=0, skid invalid, inst_valid<=0, Instruction<=32'h0, Inst_Addr<=0.
REQ-028 While rst=1, imem_req SHALL be 0. The instruction memory shares rst, so no stale rvalid follows reset.
REQ-029 First request SHALL issue in the first cycle with rst=0, at imem_addr=RESET_PC.

Verification
REQ-030 Reset release, RESET_PC=0, 1-cycle memory returning addr-based words, stall=0 -> requests at 0x0, 0x4, 0x8 on alternating cycles; inst_valid pulses with Inst_Addr 0x0, 0x4, 0x8 in order.
REQ-031 stall=1 held 5 cycles while the word for 0x4 is returning and 0x0 is in the output -> the 0x4 word goes to HOLD; no request while stalled; on release, 0x0 is consumed, then 0x4 appears; no loss and no duplicate.
REQ-032 branch_taken=1, branch_target=0x103 while in WAIT for 0x8, 3-cycle memory -> the 0x8 data is discarded; the next request is to 0x100; inst_valid=0 until the 0x100 word arrives.
REQ-033 branch_taken and imem_rvalid in the same cycle -> the data is dropped; next cycle imem_req=1 at the target; kill stays 0.
REQ-034 PC at 0xFFFF_FFFF_FFFF_FFFC -> the following request wraps to address 0x0.
REQ-035 rst=1 asserted mid-WAIT with the output valid and stall=1 -> next cycle inst_valid=0 and the FSM is in FETCH; the first post-reset request is at RESET_PC.
